id_ex_operand_stage: RTL and testbench

- Pipeline stage directly downstream of the 16x16 register file.
- Captures the two read-port values (Bitline1/Bitline2) of the instruction in decode, together with its destination and control fields, into the ID/EX boundary.
- Provides write-back bypass, so a register written this cycle is read with its new value.
- Detects load-use hazards and emits a one-cycle decode stall while inserting a bubble.
- Supports a downstream hold (held contents keep tracking write-back) and a branch flush.

---
 rtl/cpu_pkg.sv | 30 +++
 rtl/id_ex_operand_stage_if.sv | 51 +++++
 rtl/id_ex_operand_stage_bypass.sv | 27 ++
 rtl/id_ex_operand_stage.sv | 115 +++++++++++
 tb/tb_id_ex_operand_stage.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, register and opcode constants,
// EX control-bit positions, and the update action of the ID/EX stage.
package cpu_pkg;

    localparam int DW = 16;
    localparam int AW = 4;
    localparam int CW = 8;

    localparam logic [3:0] REG_ZERO = 4'd0;
    localparam logic [3:0] OPC_LW   = 4'b1000;

    // Bit positions inside the opaque EX control byte (id_ctrl / ex_ctrl)
    localparam int CTRL_ALU_OP0  = 0;
    localparam int CTRL_ALU_OP1  = 1;
    localparam int CTRL_ALU_OP2  = 2;
    localparam int CTRL_ALU_SRC  = 3;
    localparam int CTRL_MEM_RD   = 4;
    localparam int CTRL_MEM_WR   = 5;
    localparam int CTRL_BRANCH   = 6;
    localparam int CTRL_MEM2REG  = 7;

    // What the ID/EX register does on the next clock edge
    typedef enum logic [1:0] {
        ACT_CAPTURE = 2'd0,
        ACT_BUBBLE  = 2'd1,
        ACT_HOLD    = 2'd2,
        ACT_FLUSH   = 2'd3
    } stage_act_e;

endpackage

// File: rtl/id_ex_operand_stage_if.sv
// Signal bundle between decode/write-back/EX control and the ID/EX stage.
// The master side drives decode, write-back and steering inputs; the slave
// side is the stage itself.
interface id_ex_operand_stage_if #(
    parameter int DW = cpu_pkg::DW,
    parameter int AW = cpu_pkg::AW
);
    logic          id_valid;
    logic [AW-1:0] id_src1;
    logic [AW-1:0] id_src2;
    logic          id_use1;
    logic          id_use2;
    logic [DW-1:0] rf_data1;
    logic [DW-1:0] rf_data2;
    logic [AW-1:0] id_dst;
    logic          id_we;
    logic          id_is_load;
    logic [7:0]    id_ctrl;
    logic          wb_we;
    logic [AW-1:0] wb_addr;
    logic [DW-1:0] wb_data;
    logic          ex_hold;
    logic          flush;
    logic          ex_valid;
    logic [DW-1:0] ex_data1;
    logic [DW-1:0] ex_data2;
    logic [AW-1:0] ex_src1;
    logic [AW-1:0] ex_src2;
    logic [AW-1:0] ex_dst;
    logic          ex_we;
    logic          ex_is_load;
    logic [7:0]    ex_ctrl;
    logic          id_stall;

    modport master (
        output id_valid, id_src1, id_src2, id_use1, id_use2,
        output rf_data1, rf_data2, id_dst, id_we, id_is_load, id_ctrl,
        output wb_we, wb_addr, wb_data, ex_hold, flush,
        input  ex_valid, ex_data1, ex_data2, ex_src1, ex_src2,
        input  ex_dst, ex_we, ex_is_load, ex_ctrl, id_stall
    );

    modport slave (
        input  id_valid, id_src1, id_src2, id_use1, id_use2,
        input  rf_data1, rf_data2, id_dst, id_we, id_is_load, id_ctrl,
        input  wb_we, wb_addr, wb_data, ex_hold, flush,
        output ex_valid, ex_data1, ex_data2, ex_src1, ex_src2,
        output ex_dst, ex_we, ex_is_load, ex_ctrl, id_stall
    );

endinterface

// File: rtl/id_ex_operand_stage_bypass.sv
// Write-back bypass for one register-file read port: a register being
// written this cycle is read with its new value, and R0 always reads zero.
module operand_bypass
    import cpu_pkg::*;
#(
    parameter int DW = cpu_pkg::DW,
    parameter int AW = cpu_pkg::AW
) (
    input  logic [AW-1:0] src,
    input  logic [DW-1:0] rf_data,
    input  logic          wb_we,
    input  logic [AW-1:0] wb_addr,
    input  logic [DW-1:0] wb_data,
    output logic [DW-1:0] operand
);

    // Pick zero for R0, write-back data on an address hit, else the bitline
    always_comb begin
        operand = rf_data;
        if (src == AW'(REG_ZERO)) begin
            operand = '0;
        end else if (wb_we && (wb_addr == src)) begin
            operand = wb_data;
        end
    end

endmodule

// File: rtl/id_ex_operand_stage.sv
// ID/EX boundary register fed by the register file. Captures bypassed
// operands and control of the decode instruction, inserts a bubble on a
// load-use hazard, holds on downstream stall (held operands still pick up
// write-back) and empties on a branch flush.
module id_ex_operand_stage
    import cpu_pkg::*;
#(
    parameter int DW = cpu_pkg::DW,
    parameter int AW = cpu_pkg::AW
) (
    input  logic                  clk,
    input  logic                  rst,
    id_ex_operand_stage_if.slave  bus
);

    logic [DW-1:0] byp1;
    logic [DW-1:0] byp2;
    logic          hazard;
    logic          hold_wb1;
    logic          hold_wb2;
    stage_act_e    act;

    logic          valid_q;
    logic [DW-1:0] data1_q;
    logic [DW-1:0] data2_q;
    logic [AW-1:0] src1_q;
    logic [AW-1:0] src2_q;
    logic [AW-1:0] dst_q;
    logic          we_q;
    logic          load_q;
    logic [7:0]    ctrl_q;

    operand_bypass #(.DW(DW), .AW(AW)) u_byp1 (
        .src     (bus.id_src1),
        .rf_data (bus.rf_data1),
        .wb_we   (bus.wb_we),
        .wb_addr (bus.wb_addr),
        .wb_data (bus.wb_data),
        .operand (byp1)
    );

    operand_bypass #(.DW(DW), .AW(AW)) u_byp2 (
        .src     (bus.id_src2),
        .rf_data (bus.rf_data2),
        .wb_we   (bus.wb_we),
        .wb_addr (bus.wb_addr),
        .wb_data (bus.wb_data),
        .operand (byp2)
    );

    // Load-use hazard, stall request, held-operand refresh and edge action
    always_comb begin
        hazard = bus.id_valid && valid_q && load_q && we_q
                 && (dst_q != AW'(REG_ZERO))
                 && ((bus.id_use1 && (bus.id_src1 == dst_q))
                  || (bus.id_use2 && (bus.id_src2 == dst_q)));
        hold_wb1 = bus.wb_we && (bus.wb_addr == src1_q)
                   && (src1_q != AW'(REG_ZERO));
        hold_wb2 = bus.wb_we && (bus.wb_addr == src2_q)
                   && (src2_q != AW'(REG_ZERO));
        act = ACT_CAPTURE;
        if (bus.flush) begin
            act = ACT_FLUSH;
        end else if (bus.ex_hold) begin
            act = ACT_HOLD;
        end else if (hazard) begin
            act = ACT_BUBBLE;
        end
    end

    assign bus.id_stall = !bus.flush && (hazard || bus.ex_hold);

    // ID/EX register slice steered by reset, flush, hold, bubble, capture
    always_ff @(posedge clk) begin
        if (rst || (act == ACT_FLUSH) || (act == ACT_BUBBLE)) begin
            valid_q <= 1'b0;
            data1_q <= '0;
            data2_q <= '0;
            src1_q  <= '0;
            src2_q  <= '0;
            dst_q   <= '0;
            we_q    <= 1'b0;
            load_q  <= 1'b0;
            ctrl_q  <= '0;
        end else if (act == ACT_HOLD) begin
            if (hold_wb1) begin
                data1_q <= bus.wb_data;
            end
            if (hold_wb2) begin
                data2_q <= bus.wb_data;
            end
        end else begin
            valid_q <= bus.id_valid;
            data1_q <= byp1;
            data2_q <= byp2;
            src1_q  <= bus.id_src1;
            src2_q  <= bus.id_src2;
            dst_q   <= bus.id_dst;
            we_q    <= bus.id_we;
            load_q  <= bus.id_is_load;
            ctrl_q  <= bus.id_ctrl;
        end
    end

    assign bus.ex_valid   = valid_q;
    assign bus.ex_data1   = data1_q;
    assign bus.ex_data2   = data2_q;
    assign bus.ex_src1    = src1_q;
    assign bus.ex_src2    = src2_q;
    assign bus.ex_dst     = dst_q;
    assign bus.ex_we      = we_q;
    assign bus.ex_is_load = load_q;
    assign bus.ex_ctrl    = ctrl_q;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Directed bench for the ID/EX operand stage: a table of single-cycle
// capture/bypass vectors followed by hand-written load-use, hold, flush
// and reset sequences.
module tb_id_ex_operand_stage;
    import cpu_pkg::*;

    typedef struct {
        logic          id_valid;
        logic [3:0]    src1;
        logic [3:0]    src2;
        logic          use1;
        logic          use2;
        logic [15:0]   rf1;
        logic [15:0]   rf2;
        logic [3:0]    dst;
        logic          we;
        logic          ld;
        logic [7:0]    ctrl;
        logic          wb_we;
        logic [3:0]    wb_addr;
        logic [15:0]   wb_data;
        logic          e_valid;
        logic [15:0]   e_d1;
        logic [15:0]   e_d2;
        logic [3:0]    e_dst;
        logic          e_we;
        logic          e_ld;
        logic [7:0]    e_ctrl;
    } vec_t;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    vec_t vecs[12];
    vec_t v;

    id_ex_operand_stage_if #(.DW(DW), .AW(AW)) bus ();

    id_ex_operand_stage #(.DW(DW), .AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t s);
        bus.id_valid   = s.id_valid;
        bus.id_src1    = s.src1;
        bus.id_src2    = s.src2;
        bus.id_use1    = s.use1;
        bus.id_use2    = s.use2;
        bus.rf_data1   = s.rf1;
        bus.rf_data2   = s.rf2;
        bus.id_dst     = s.dst;
        bus.id_we      = s.we;
        bus.id_is_load = s.ld;
        bus.id_ctrl    = s.ctrl;
        bus.wb_we      = s.wb_we;
        bus.wb_addr    = s.wb_addr;
        bus.wb_data    = s.wb_data;
    endtask

    task automatic stepEdge();
        @(posedge clk);
        #1;
    endtask

    task automatic checkEmpty(input string tag);
        checkOutput({tag, ".valid"}, 16'(bus.ex_valid), 16'h0);
        checkOutput({tag, ".d1"}, bus.ex_data1, 16'h0);
        checkOutput({tag, ".d2"}, bus.ex_data2, 16'h0);
        checkOutput({tag, ".src1"}, 16'(bus.ex_src1), 16'h0);
        checkOutput({tag, ".src2"}, 16'(bus.ex_src2), 16'h0);
        checkOutput({tag, ".dst"}, 16'(bus.ex_dst), 16'h0);
        checkOutput({tag, ".we"}, 16'(bus.ex_we), 16'h0);
        checkOutput({tag, ".ld"}, 16'(bus.ex_is_load), 16'h0);
        checkOutput({tag, ".ctrl"}, 16'(bus.ex_ctrl), 16'h0);
    endtask

    initial begin
        total = 0;
        bad   = 0;

        //            vld s1 s2 u1 u2 rf1      rf2      dst we ld ctrl   wbwe wba wbd        ev d1       d2       dst we ld ctrl
        vecs[0]  = '{1, 3, 5, 1, 1, 16'h1111, 16'h2222, 6, 1, 0, 8'h5A, 0, 0, 16'h0000, 1, 16'h1111, 16'h2222, 6, 1, 0, 8'h5A};
        vecs[1]  = '{1, 3, 5, 1, 1, 16'h0000, 16'h2222, 6, 1, 0, 8'h5A, 1, 3, 16'hBEEF, 1, 16'hBEEF, 16'h2222, 6, 1, 0, 8'h5A};
        vecs[2]  = '{1, 0, 9, 1, 1, 16'hABCD, 16'h1234, 7, 1, 0, 8'h11, 1, 0, 16'hFFFF, 1, 16'h0000, 16'h1234, 7, 1, 0, 8'h11};
        vecs[3]  = '{1, 2, 2, 1, 1, 16'h0102, 16'h0102, 3, 0, 0, 8'h22, 1, 2, 16'h7777, 1, 16'h7777, 16'h7777, 3, 0, 0, 8'h22};
        vecs[4]  = '{0, 1, 6, 1, 1, 16'h0001, 16'h0006, 1, 1, 0, 8'h33, 0, 0, 16'h0000, 0, 16'h0001, 16'h0006, 1, 1, 0, 8'h33};
        vecs[5]  = '{1, 4, 10, 1, 0, 16'h4444, 16'hAAAA, 4, 1, 0, 8'h44, 0, 4, 16'h9999, 1, 16'h4444, 16'hAAAA, 4, 1, 0, 8'h44};
        vecs[6]  = '{1, 1, 2, 1, 1, 16'h1000, 16'h2000, 8, 1, 1, 8'h81, 0, 0, 16'h0000, 1, 16'h1000, 16'h2000, 8, 1, 1, 8'h81};
        vecs[7]  = '{1, 8, 8, 0, 0, 16'h8888, 16'h8888, 9, 1, 0, 8'h55, 0, 0, 16'h0000, 1, 16'h8888, 16'h8888, 9, 1, 0, 8'h55};
        vecs[8]  = '{1, 3, 4, 1, 1, 16'h0300, 16'h0400, 0, 1, 1, 8'h81, 0, 0, 16'h0000, 1, 16'h0300, 16'h0400, 0, 1, 1, 8'h81};
        vecs[9]  = '{1, 0, 0, 1, 1, 16'h5555, 16'h5555, 5, 1, 0, 8'h66, 0, 0, 16'h0000, 1, 16'h0000, 16'h0000, 5, 1, 0, 8'h66};
        vecs[10] = '{1, 1, 1, 1, 1, 16'h0011, 16'h0011, 5, 0, 1, 8'h81, 0, 0, 16'h0000, 1, 16'h0011, 16'h0011, 5, 0, 1, 8'h81};
        vecs[11] = '{1, 5, 5, 1, 1, 16'h0555, 16'h0555, 12, 1, 0, 8'h77, 1, 5, 16'h0F0F, 1, 16'h0F0F, 16'h0F0F, 12, 1, 0, 8'h77};

        // Reset with everything idle
        v = '{0, 0, 0, 0, 0, 16'h0, 16'h0, 0, 0, 0, 8'h0, 0, 0, 16'h0, 0, 16'h0, 16'h0, 0, 0, 0, 8'h0};
        applyStimulus(v);
        bus.ex_hold = 1'b0;
        bus.flush   = 1'b0;
        rst = 1'b1;
        stepEdge();
        stepEdge();
        rst = 1'b0;
        checkEmpty("reset");
        checkOutput("reset.stall", 16'(bus.id_stall), 16'h0);

        // Table of plain capture / bypass vectors, none of which stall
        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i]);
            #1;
            checkOutput($sformatf("v%0d.stall", i), 16'(bus.id_stall), 16'h0);
            stepEdge();
            checkOutput($sformatf("v%0d.valid", i), 16'(bus.ex_valid), 16'(vecs[i].e_valid));
            checkOutput($sformatf("v%0d.d1", i), bus.ex_data1, vecs[i].e_d1);
            checkOutput($sformatf("v%0d.d2", i), bus.ex_data2, vecs[i].e_d2);
            checkOutput($sformatf("v%0d.src1", i), 16'(bus.ex_src1), 16'(vecs[i].src1));
            checkOutput($sformatf("v%0d.src2", i), 16'(bus.ex_src2), 16'(vecs[i].src2));
            checkOutput($sformatf("v%0d.dst", i), 16'(bus.ex_dst), 16'(vecs[i].e_dst));
            checkOutput($sformatf("v%0d.we", i), 16'(bus.ex_we), 16'(vecs[i].e_we));
            checkOutput($sformatf("v%0d.ld", i), 16'(bus.ex_is_load), 16'(vecs[i].e_ld));
            checkOutput($sformatf("v%0d.ctrl", i), 16'(bus.ex_ctrl), 16'(vecs[i].e_ctrl));
        end

        // Load-use: LW R4 in EX, decode reads R4 on port 2
        v = '{1, 1, 2, 1, 1, 16'h0001, 16'h0002, 4, 1, 1, 8'h81, 0, 0, 16'h0, 0, 16'h0, 16'h0, 0, 0, 0, 8'h0};
        applyStimulus(v);
        stepEdge();
        checkOutput("lu.lw_ld", 16'(bus.ex_is_load), 16'h1);
        v = '{1, 6, 4, 1, 1, 16'h0606, 16'h0404, 9, 1, 0, 8'h33, 0, 0, 16'h0, 0, 16'h0, 16'h0, 0, 0, 0, 8'h0};
        applyStimulus(v);
        #1;
        checkOutput("lu.stall", 16'(bus.id_stall), 16'h1);
        stepEdge();
        checkOutput("lu.bub_valid", 16'(bus.ex_valid), 16'h0);
        checkOutput("lu.bub_we", 16'(bus.ex_we), 16'h0);
        checkOutput("lu.bub_ld", 16'(bus.ex_is_load), 16'h0);
        checkOutput("lu.stall2", 16'(bus.id_stall), 16'h0);
        stepEdge();
        checkOutput("lu.cap_valid", 16'(bus.ex_valid), 16'h1);
        checkOutput("lu.cap_d1", bus.ex_data1, 16'h0606);
        checkOutput("lu.cap_d2", bus.ex_data2, 16'h0404);
        checkOutput("lu.cap_dst", 16'(bus.ex_dst), 16'h9);
        checkOutput("lu.cap_ctrl", 16'(bus.ex_ctrl), 16'h33);
        checkOutput("lu.stall3", 16'(bus.id_stall), 16'h0);

        // Hold for three cycles while write-back updates held source R7
        v = '{1, 7, 3, 1, 1, 16'h0070, 16'h0030, 2, 1, 0, 8'hC3, 0, 0, 16'h0, 0, 16'h0, 16'h0, 0, 0, 0, 8'h0};
        applyStimulus(v);
        stepEdge();
        v = '{1, 1, 1, 1, 1, 16'hDEAD, 16'hDEAD, 15, 1, 0, 8'hFF, 0, 0, 16'h0, 0, 16'h0, 16'h0, 0, 0, 0, 8'h0};
        applyStimulus(v);
        bus.ex_hold = 1'b1;
        #1;
        checkOutput("hold.stall1", 16'(bus.id_stall), 16'h1);
        stepEdge();
        checkOutput("hold.c1_d1", bus.ex_data1, 16'h0070);
        bus.wb_we   = 1'b1;
        bus.wb_addr = 4'd7;
        bus.wb_data = 16'h00A5;
        #1;
        checkOutput("hold.stall2", 16'(bus.id_stall), 16'h1);
        stepEdge();
        checkOutput("hold.c2_d1", bus.ex_data1, 16'h00A5);
        checkOutput("hold.c2_d2", bus.ex_data2, 16'h0030);
        bus.wb_addr = 4'd0;
        bus.wb_data = 16'hFFFF;
        #1;
        checkOutput("hold.stall3", 16'(bus.id_stall), 16'h1);
        stepEdge();
        checkOutput("hold.c3_d1", bus.ex_data1, 16'h00A5);
        checkOutput("hold.c3_valid", 16'(bus.ex_valid), 16'h1);
        checkOutput("hold.c3_dst", 16'(bus.ex_dst), 16'h2);
        checkOutput("hold.c3_src1", 16'(bus.ex_src1), 16'h7);
        checkOutput("hold.c3_ctrl", 16'(bus.ex_ctrl), 16'hC3);
        bus.ex_hold = 1'b0;
        bus.wb_we   = 1'b0;
        stepEdge();
        checkOutput("hold.rel_d1", bus.ex_data1, 16'hDEAD);
        checkOutput("hold.rel_dst", 16'(bus.ex_dst), 16'hF);

        // Flush beats a simultaneous hazard and hold
        v = '{1, 1, 2, 1, 1, 16'h0001, 16'h0002, 4, 1, 1, 8'h81, 0, 0, 16'h0, 0, 16'h0, 16'h0, 0, 0, 0, 8'h0};
        applyStimulus(v);
        stepEdge();
        v = '{1, 6, 4, 1, 1, 16'h0606, 16'h0404, 9, 1, 0, 8'h33, 0, 0, 16'h0, 0, 16'h0, 16'h0, 0, 0, 0, 8'h0};
        applyStimulus(v);
        bus.ex_hold = 1'b1;
        bus.flush   = 1'b1;
        #1;
        checkOutput("flush.stall", 16'(bus.id_stall), 16'h0);
        stepEdge();
        checkEmpty("flush");
        bus.ex_hold = 1'b0;
        bus.flush   = 1'b0;

        // Reset pulse in the middle of a hold
        stepEdge();
        checkOutput("rsthold.pre_valid", 16'(bus.ex_valid), 16'h1);
        bus.ex_hold = 1'b1;
        stepEdge();
        rst = 1'b1;
        stepEdge();
        checkEmpty("rsthold");
        checkOutput("rsthold.stall", 16'(bus.id_stall), 16'h1);
        rst = 1'b0;
        bus.ex_hold = 1'b0;
        stepEdge();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
